// File: rtl/tx_medida_serial_pkg.sv
// Shared definitions for the distance serial reporter: state codes, ASCII constants
// and the BCD-digit-to-character helper.
package tx_medida_serial_pkg;

    typedef enum logic [2:0] {
        ST_OCIOSO = 3'd0,
        ST_START  = 3'd1,
        ST_DADOS  = 3'd2,
        ST_STOP   = 3'd3,
        ST_FIM    = 3'd4
    } estado_t;

    // Bit-level phase of the 8N1 transmitter.
    typedef enum logic [1:0] {
        FS_LIVRE = 2'd0,
        FS_START = 2'd1,
        FS_DADOS = 2'd2,
        FS_STOP  = 2'd3
    } fase_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_ERRO = 8'h3F;

    // Non-decimal nibbles become '?' so a corrupted measurement is visible on the terminal.
    function automatic logic [7:0] ascii_digito(input logic [3:0] nibble);
        logic [7:0] resultado;
        if (nibble > 4'd9) begin
            resultado = ASCII_ERRO;
        end else begin
            resultado = ASCII_ZERO + {4'd0, nibble};
        end
        return resultado;
    endfunction

endpackage

// File: rtl/tx_medida_serial_tx_serial_8n1.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit, DIVISOR cycles each.
// A partida asserted during the last stop cycle chains the next byte with no idle gap.
module tx_serial_8n1
    import tx_medida_serial_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dado,
    input  logic       partida,
    output logic       saida,
    output logic       fim_fase,
    output logic       fim_char
);

    localparam logic [11:0] BAUD_MAX = 12'(DIVISOR - 1);

    fase_t       fase_reg, fase_next;
    logic [11:0] baud_reg, baud_next;
    logic [2:0]  bit_reg, bit_next;
    logic        saida_reg, saida_next;
    logic        fim_bit;
    logic [2:0]  bit_inc;

    assign fim_bit = (baud_reg == BAUD_MAX);
    assign bit_inc = bit_reg + 3'd1;
    assign saida   = saida_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fase_reg  <= FS_LIVRE;
            baud_reg  <= 12'd0;
            bit_reg   <= 3'd0;
            saida_reg <= 1'b1;
        end else begin
            fase_reg  <= fase_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            saida_reg <= saida_next;
        end
    end

    // dado is read live during the data phase; the caller keeps it stable for the whole byte.
    always_comb begin
        fase_next  = fase_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        saida_next = saida_reg;
        fim_fase   = 1'b0;
        fim_char   = 1'b0;

        if (fase_reg != FS_LIVRE) begin
            baud_next = fim_bit ? 12'd0 : baud_reg + 12'd1;
        end

        case (fase_reg)
            FS_LIVRE: begin
                saida_next = 1'b1;
                if (partida) begin
                    fase_next  = FS_START;
                    baud_next  = 12'd0;
                    saida_next = 1'b0;
                end
            end
            FS_START: begin
                if (fim_bit) begin
                    fim_fase   = 1'b1;
                    fase_next  = FS_DADOS;
                    bit_next   = 3'd0;
                    saida_next = dado[0];
                end
            end
            FS_DADOS: begin
                if (fim_bit) begin
                    if (bit_reg == 3'd7) begin
                        fim_fase   = 1'b1;
                        fase_next  = FS_STOP;
                        saida_next = 1'b1;
                    end else begin
                        bit_next   = bit_inc;
                        saida_next = dado[bit_inc];
                    end
                end
            end
            FS_STOP: begin
                if (fim_bit) begin
                    fim_char = 1'b1;
                    if (partida) begin
                        fase_next  = FS_START;
                        saida_next = 1'b0;
                    end else begin
                        fase_next  = FS_LIVRE;
                        saida_next = 1'b1;
                    end
                end
            end
            default: begin
                fase_next  = FS_LIVRE;
                saida_next = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tx_medida_serial.sv
// Captures a 3-digit BCD distance on the rising edge of pronto and sends it as "DDD#"
// over an 8N1 UART line; edges arriving while a frame is in flight are dropped.
module tx_medida_serial
    import tx_medida_serial_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] medida,
    input  logic        pronto,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto_tx,
    output logic [3:0]  db_estado
);

    estado_t     estado_reg, estado_next;
    logic        pronto_d_reg;
    logic [11:0] medida_reg, medida_next;
    logic [1:0]  indice_reg, indice_next;
    logic        borda;
    logic [7:0]  caractere;
    logic        partida;
    logic        fim_fase;
    logic        fim_char;

    assign borda     = pronto & ~pronto_d_reg;
    assign db_estado = {1'b0, estado_reg};

    always_comb begin
        case (indice_reg)
            2'd0:    caractere = ascii_digito(medida_reg[11:8]);
            2'd1:    caractere = ascii_digito(medida_reg[7:4]);
            2'd2:    caractere = ascii_digito(medida_reg[3:0]);
            default: caractere = ASCII_HASH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg   <= ST_OCIOSO;
            pronto_d_reg <= 1'b0;
            medida_reg   <= 12'd0;
            indice_reg   <= 2'd0;
        end else begin
            estado_reg   <= estado_next;
            pronto_d_reg <= pronto;
            medida_reg   <= medida_next;
            indice_reg   <= indice_next;
        end
    end

    // Frame sequencing follows the transmitter's phase and character completion strobes.
    always_comb begin
        estado_next = estado_reg;
        medida_next = medida_reg;
        indice_next = indice_reg;
        partida     = 1'b0;
        ocupado     = 1'b0;
        pronto_tx   = 1'b0;

        case (estado_reg)
            ST_OCIOSO: begin
                if (borda) begin
                    medida_next = medida;
                    indice_next = 2'd0;
                    partida     = 1'b1;
                    estado_next = ST_START;
                end
            end
            ST_START: begin
                ocupado = 1'b1;
                if (fim_fase) begin
                    estado_next = ST_DADOS;
                end
            end
            ST_DADOS: begin
                ocupado = 1'b1;
                if (fim_fase) begin
                    estado_next = ST_STOP;
                end
            end
            ST_STOP: begin
                ocupado = 1'b1;
                if (fim_char) begin
                    if (indice_reg < 2'd3) begin
                        indice_next = indice_reg + 2'd1;
                        partida     = 1'b1;
                        estado_next = ST_START;
                    end else begin
                        estado_next = ST_FIM;
                    end
                end
            end
            ST_FIM: begin
                pronto_tx   = 1'b1;
                estado_next = ST_OCIOSO;
            end
            default: begin
                estado_next = ST_OCIOSO;
            end
        endcase
    end

    tx_serial_8n1 #(
        .DIVISOR(DIVISOR)
    ) u_tx (
        .clock   (clock),
        .reset   (reset),
        .dado    (caractere),
        .partida (partida),
        .saida   (saida_serial),
        .fim_fase(fim_fase),
        .fim_char(fim_char)
    );

endmodule
